// File: rtl/nf_cc_slave_router_if.sv
// nf_cc_slave_router_if
//   Request bus from the CPU cross-connect into the slave router (the "cc bus").
//   master modport: driven by the cross-connect (addr/wd/we/req), sees rd/req_ack.
//   slave  modport: used by the router, returns rd_cc and the one-cycle req_ack_cc.
//   addr_cc    [31:0]  request address
//   wd_cc      [31:0]  write data
//   we_cc              write enable (1 = write, 0 = read)
//   req_cc             request, held by the master until req_ack_cc
//   rd_cc      [31:0]  read data, zero unless req_ack_cc = 1
//   req_ack_cc         one-cycle transaction-complete pulse
interface nf_cc_slave_router_if;
    logic [31:0] addr_cc;
    logic [31:0] wd_cc;
    logic        we_cc;
    logic        req_cc;
    logic [31:0] rd_cc;
    logic        req_ack_cc;

    modport master (
        output addr_cc,
        output wd_cc,
        output we_cc,
        output req_cc,
        input  rd_cc,
        input  req_ack_cc
    );

    modport slave (
        input  addr_cc,
        input  wd_cc,
        input  we_cc,
        input  req_cc,
        output rd_cc,
        output req_ack_cc
    );
endinterface

// File: rtl/nf_cc_slave_router.sv
// nf_cc_slave_router
//   Decodes the single arbitrated cc-bus request to one of SLV_N slaves, keeps one
//   transaction outstanding and returns a registered one-cycle ack. Unmapped addresses
//   and slaves that do not ack within TIMEOUT cycles get an error response (ERR_DATA).
// Ports
//   clk, resetn    clock, asynchronous active-low reset
//   cc_io          cc bus (slave modport): addr/wd/we/req in, rd/req_ack out
//   addr_s_o       latched address broadcast to all slaves
//   wd_s_o         latched write data broadcast
//   we_s_o         per-slave write enable
//   req_s_o        per-slave request, one-hot or zero
//   rd_s_i         per-slave read data, slice [32*i +: 32]
//   req_ack_s_i    per-slave ack pulse
//   err_o          one-cycle error pulse, coincident with req_ack_cc
//   err_addr_o     address of the most recent faulting request
module nf_cc_slave_router #(
    parameter int unsigned         SLV_N      = 4,
    parameter logic [SLV_N*32-1:0] ADDR_MASK  = {SLV_N{32'hF000_0000}},
    parameter logic [SLV_N*32-1:0] ADDR_MATCH = {32'h3000_0000, 32'h2000_0000,
                                                 32'h1000_0000, 32'h0000_0000},
    parameter int unsigned         TIMEOUT    = 255,
    parameter logic [31:0]         ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    nf_cc_slave_router_if.slave       cc_io,
    output logic [31:0]               addr_s_o,
    output logic [31:0]               wd_s_o,
    output logic [SLV_N-1:0]          we_s_o,
    output logic [SLV_N-1:0]          req_s_o,
    input  logic [SLV_N*32-1:0]       rd_s_i,
    input  logic [SLV_N-1:0]          req_ack_s_i,
    output logic                      err_o,
    output logic [31:0]               err_addr_o
);

    localparam int unsigned SelW = (SLV_N > 1) ? $clog2(SLV_N) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

    state_e            state_q;
    logic [SelW-1:0]   sel_q;
    logic [CntW-1:0]   cnt_q;
    logic [31:0]       rd_q;
    logic [31:0]       addr_q;
    logic [31:0]       wd_q;
    logic [SLV_N-1:0]  req_s_q;
    logic [SLV_N-1:0]  we_s_q;
    logic              ack_q;
    logic              err_pend_q;
    logic [31:0]       err_addr_q;

    // Address decode; scanning downwards lets the lowest matching index win on overlap.
    logic            hit;
    logic [SelW-1:0] hit_idx;
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = SLV_N - 1; i >= 0; i--) begin
            if ((cc_io.addr_cc & ADDR_MASK[32*i +: 32]) == ADDR_MATCH[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SelW'(i);
            end
        end
    end

    // Only the selected slave's ack/data are visible; everything else is ignored.
    logic        ack_sel;
    logic [31:0] rd_sel;
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        for (int i = 0; i < SLV_N; i++) begin
            if (sel_q == SelW'(i)) begin
                ack_sel = req_ack_s_i[i];
                rd_sel  = rd_s_i[32*i +: 32];
            end
        end
    end

    logic terminal;
    assign terminal = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            req_s_q    <= '0;
            we_s_q     <= '0;
            ack_q      <= 1'b0;
            err_pend_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            ack_q      <= 1'b0;
            err_pend_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cc_io.req_cc) begin
                        addr_q <= cc_io.addr_cc;
                        wd_q   <= cc_io.wd_cc;
                        if (hit) begin
                            sel_q   <= hit_idx;
                            cnt_q   <= '0;
                            req_s_q <= SLV_N'(1) << hit_idx;
                            // The latched write enable lives directly in we_s_q.
                            we_s_q  <= cc_io.we_cc ? (SLV_N'(1) << hit_idx) : '0;
                            state_q <= StActive;
                        end else begin
                            rd_q       <= ERR_DATA;
                            err_addr_q <= cc_io.addr_cc;
                            err_pend_q <= 1'b1;
                            ack_q      <= 1'b1;
                            state_q    <= StResp;
                        end
                    end
                end
                StActive: begin
                    // req_cc is not looked at here: a started transaction always completes.
                    if (ack_sel) begin
                        rd_q    <= rd_sel;
                        req_s_q <= '0;
                        we_s_q  <= '0;
                        ack_q   <= 1'b1;
                        state_q <= StResp;
                    end else if (terminal) begin
                        rd_q       <= ERR_DATA;
                        err_addr_q <= addr_q;
                        err_pend_q <= 1'b1;
                        req_s_q    <= '0;
                        we_s_q     <= '0;
                        ack_q      <= 1'b1;
                        state_q    <= StResp;
                    end else if (cnt_q != CntW'(TIMEOUT)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cc_io.rd_cc      = ack_q ? rd_q : '0;
    assign cc_io.req_ack_cc = ack_q;
    assign addr_s_o         = addr_q;
    assign wd_s_o           = wd_q;
    assign we_s_o           = we_s_q;
    assign req_s_o          = req_s_q;
    assign err_o            = err_pend_q;
    assign err_addr_o       = err_addr_q;

endmodule

// File: tb/tb_nf_cc_slave_router.sv
// tb_nf_cc_slave_router
//   Randomized bench with a scoreboard. The driver computes each transaction's expected
//   response from the address map and slave wait time, pushes it into a queue, and a
//   separate monitor pops and compares whenever req_ack_cc is seen. A slave model answers
//   req_s after a chosen delay and sprays random acks on unselected slaves.
module tb_nf_cc_slave_router;

    localparam int unsigned SLV_N    = 4;
    localparam int unsigned TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    // Slave 3 overlaps slaves 0..2; lowest index must win, so it only owns 0x3xxx_xxxx.
    localparam logic [127:0] MASK  = {32'hC000_0000, 32'hF000_0000,
                                      32'hF000_0000, 32'hF000_0000};
    localparam logic [127:0] MATCH = {32'h0000_0000, 32'h2000_0000,
                                      32'h1000_0000, 32'h0000_0000};
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  addr_s, wd_s, err_addr;
    logic [3:0]   we_s, req_s, req_ack_s;
    logic [127:0] rd_s;
    logic         err;

    always #5 clk = ~clk;

    nf_cc_slave_router_if cc_if ();

    nf_cc_slave_router #(
        .SLV_N      (SLV_N),
        .ADDR_MASK  (MASK),
        .ADDR_MATCH (MATCH),
        .TIMEOUT    (TIMEOUT),
        .ERR_DATA   (ERR_DATA)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cc_io       (cc_if),
        .addr_s_o    (addr_s),
        .wd_s_o      (wd_s),
        .we_s_o      (we_s),
        .req_s_o     (req_s),
        .rd_s_i      (rd_s),
        .req_ack_s_i (req_ack_s),
        .err_o       (err),
        .err_addr_o  (err_addr)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic [31:0] err_addr;
        int          lat;
        int          issue;
    } exp_t;
    exp_t sb_q[$];

    // Expectations shared with the slave model
    logic [3:0]  exp_req_s, exp_we_s;
    logic [31:0] exp_addr, exp_wd, sl_data;
    int          sl_delay;
    logic [31:0] m_err_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < SLV_N; i++) begin
            if ((a & MASK[32*i +: 32]) == MATCH[32*i +: 32]) return i;
        end
        return -1;
    endfunction

    // Slave model
    initial begin
        int seen;
        seen      = 0;
        req_ack_s = '0;
        rd_s      = '0;
        forever begin
            @(negedge clk);
            rd_s = {$urandom, $urandom, $urandom, $urandom};
            if (resetn && req_s != 4'b0000) begin
                seen++;
                if (seen == 1) begin
                    chk("req_s", {28'b0, req_s}, {28'b0, exp_req_s});
                    chk("we_s", {28'b0, we_s}, {28'b0, exp_we_s});
                    chk("addr_s", addr_s, exp_addr);
                    chk("wd_s", wd_s, exp_wd);
                end
                req_ack_s = 4'($urandom) & ~req_s;
                for (int i = 0; i < 4; i++) begin
                    if (req_s[i]) begin
                        rd_s[32*i +: 32] = sl_data;
                        if (seen - 1 == sl_delay) req_ack_s[i] = 1'b1;
                    end
                end
            end else begin
                seen      = 0;
                req_ack_s = 4'($urandom);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (cc_if.req_ack_cc) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack actual=1 required=0");
                    end else begin
                        e = sb_q.pop_front();
                        chk("rd_cc", cc_if.rd_cc, e.rd);
                        chk("err", {31'b0, err}, {31'b0, e.err});
                        chk("err_addr", err_addr, e.err_addr);
                        chk("latency", edge_cnt - e.issue + 1, e.lat);
                    end
                end else begin
                    chk("rd_cc_idle", cc_if.rd_cc, 32'h0);
                    chk("err_idle", {31'b0, err}, 32'h0);
                end
            end
        end
    end

    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input int delay, input logic [31:0] data, input bit hold);
        exp_t e;
        int   s;
        bit   done;
        s = ref_decode(a);
        @(negedge clk);
        if (s < 0) begin
            m_err_addr = a;
            e.rd  = ERR_DATA;
            e.err = 1'b1;
            e.lat = 1;
        end else if (delay + 1 <= TIMEOUT) begin
            e.rd  = data;
            e.err = 1'b0;
            e.lat = delay + 2;
        end else begin
            m_err_addr = a;
            e.rd  = ERR_DATA;
            e.err = 1'b1;
            e.lat = TIMEOUT + 1;
        end
        e.err_addr = m_err_addr;
        e.issue    = edge_cnt + 1;
        exp_req_s  = (s < 0) ? 4'b0000 : (4'b0001 << s);
        exp_we_s   = we ? exp_req_s : 4'b0000;
        exp_addr   = a;
        exp_wd     = wd;
        sl_delay   = delay;
        sl_data    = data;
        sb_q.push_back(e);
        cc_if.addr_cc = a;
        cc_if.wd_cc   = wd;
        cc_if.we_cc   = we;
        cc_if.req_cc  = 1'b1;
        done = 1'b0;
        for (int n = 0; n < int'(TIMEOUT) + 10 && !done; n++) begin
            @(negedge clk);
            done = cc_if.req_ack_cc;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_wait actual=none required=req_ack_cc addr=%h", a);
        end
        if (hold) @(negedge clk);
        cc_if.req_cc  = 1'b0;
        cc_if.addr_cc = $urandom;
        cc_if.wd_cc   = $urandom;
        cc_if.we_cc   = 1'($urandom);
    endtask

    initial begin
        cc_if.addr_cc = '0;
        cc_if.wd_cc   = '0;
        cc_if.we_cc   = 1'b0;
        cc_if.req_cc  = 1'b0;
        #1;
        chk("rst_rd_cc", cc_if.rd_cc, 32'h0);
        chk("rst_req_ack", {31'b0, cc_if.req_ack_cc}, 32'h0);
        chk("rst_req_s", {28'b0, req_s}, 32'h0);
        chk("rst_we_s", {28'b0, we_s}, 32'h0);
        chk("rst_addr_s", addr_s, 32'h0);
        chk("rst_wd_s", wd_s, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Write to slave 1, zero-wait
        run_txn(32'h1000_0004, 32'h0000_0055, 1'b1, 0, 32'h0BAD_0001, 1'b0);
        // Read from slave 0 with 3 wait cycles
        run_txn(32'h0000_0010, 32'h0, 1'b0, 3, 32'h1234_5678, 1'b0);
        // Unmapped
        run_txn(32'h9000_0000, 32'h0, 1'b0, 0, 32'h0, 1'b0);
        // Timeout on slave 2, then ack exactly on the terminal count
        run_txn(32'h2000_0000, 32'h0000_00AA, 1'b1, NEVER, 32'h0, 1'b0);
        run_txn(32'h2000_0008, 32'h0, 1'b0, int'(TIMEOUT) - 1, 32'hCAFE_F00D, 1'b0);
        // Overlap region owned only by slave 3
        run_txn(32'h3000_0020, 32'h0000_1111, 1'b1, 1, 32'h3333_0000, 1'b0);
        // Master holds req_cc through RESP: exactly one transaction
        run_txn(32'h0000_0100, 32'h0, 1'b0, 2, 32'hA5A5_5A5A, 1'b1);
        repeat (3) @(negedge clk);

        // Reset while ACTIVE
        exp_req_s = 4'b0010;
        exp_we_s  = 4'b0000;
        exp_addr  = 32'h1000_0000;
        exp_wd    = 32'h0000_0077;
        sl_delay  = NEVER;
        sl_data   = 32'h0;
        cc_if.addr_cc = 32'h1000_0000;
        cc_if.wd_cc   = 32'h0000_0077;
        cc_if.we_cc   = 1'b0;
        cc_if.req_cc  = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_req_s", {28'b0, req_s}, 32'h2);
        resetn = 1'b0;
        #1;
        chk("mid_rst_req_s", {28'b0, req_s}, 32'h0);
        chk("mid_rst_we_s", {28'b0, we_s}, 32'h0);
        chk("mid_rst_ack", {31'b0, cc_if.req_ack_cc}, 32'h0);
        chk("mid_rst_err_addr", err_addr, 32'h0);
        m_err_addr   = '0;
        cc_if.req_cc = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_txn(32'h3000_0040, 32'h0000_4242, 1'b1, 2, 32'h0000_9999, 1'b0);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            int          r, rd_sel, dly;
            a = $urandom;
            r = $urandom_range(0, 5);
            if (r < 4) a[31:28] = 4'(r);
            else a[31:28] = 4'($urandom_range(4, 15));
            rd_sel = $urandom_range(0, 9);
            if (rd_sel < 6) dly = $urandom_range(0, 3);
            else if (rd_sel == 6) dly = int'(TIMEOUT) - 1;
            else if (rd_sel == 7) dly = int'(TIMEOUT);
            else if (rd_sel == 8) dly = NEVER;
            else dly = $urandom_range(4, TIMEOUT - 2);
            run_txn(a, $urandom, 1'($urandom), dly, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
